// File: rtl/prod_pkg.sv
// Shared definitions for the product accumulator.
//   PROD_W_DEF : default unsigned product width (24x24 multiplier output)
//   ACC_W_DEF  : default accumulator / result width
//   CNT_W      : width of the per-block product counter (BLOCK_LEN up to 255)
//   state_e    : control FSM states (ACCUM collects products, HOLD presents a result)
package prod_pkg;

   localparam int unsigned PROD_W_DEF = 48;
   localparam int unsigned ACC_W_DEF  = 56;
   localparam int unsigned CNT_W      = 8;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/prod_accum_ctrl.sv
// Control path of prod_accum: block counter and the ACCUM/HOLD handshake FSM.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream product present
//   clear      : synchronous abort of the partial block (ignored in HOLD)
//   out_ready  : downstream takes the result
//   in_ready   : product can be accepted this cycle
//   last       : strobe, this cycle's accept completes the block
//   out_valid  : registered, result present (FSM is in HOLD)
module prod_accum_ctrl
   import prod_pkg::*;
#(
   parameter int unsigned BLOCK_LEN = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic clear,
   input  logic out_ready,
   output logic in_ready,
   output logic last,
   output logic out_valid
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             out_valid_q;
   logic             accept;

   // in_ready is low during reset and during a clear cycle, so clear never
   // collides with an accept.
   assign in_ready  = ~rst & (state_q == ACCUM) & ~clear;
   assign accept    = in_valid & in_ready;
   assign last      = accept & (cnt_q == LAST_CNT);
   assign out_valid = out_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACCUM;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (clear) begin
                  cnt_q <= '0;
               end else if (accept) begin
                  if (cnt_q == LAST_CNT) begin
                     cnt_q       <= '0;
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= ACCUM;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ACCUM;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/prod_accum.sv
// Block accumulator: sums BLOCK_LEN unsigned products and presents each block
// sum with a sticky overflow flag through a valid/ready handshake.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : product handshake, in_data is the unsigned product
//   clear                : abort the partial block (ignored while a result is held)
//   out_valid/out_ready  : result handshake
//   out_data             : block sum (ACC_W bits)
//   out_ovf              : some addition in the block carried beyond ACC_W bits
// Build option:
//   PROD_ACCUM_SAT_EN    : defined -> an overflowing block clamps to 2^ACC_W-1;
//                          undefined -> the accumulator wraps modulo 2^ACC_W.
module prod_accum
   import prod_pkg::*;
#(
   parameter int unsigned PROD_W    = PROD_W_DEF,
   parameter int unsigned ACC_W     = ACC_W_DEF,
   parameter int unsigned BLOCK_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_data,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_ovf
);

   logic             last;
   logic             accept;
   logic [ACC_W-1:0] acc_q;
   logic             ovf_q;
   logic [ACC_W-1:0] out_data_q;
   logic             out_ovf_q;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_add;
   logic             ovf_add;

   prod_accum_ctrl #(
      .BLOCK_LEN (BLOCK_LEN)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .clear     (clear),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .last      (last),
      .out_valid (out_valid)
   );

   assign accept = in_valid & in_ready;

   always_comb begin
      sum     = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
      ovf_add = ovf_q | sum[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
      // Once the block has overflowed the accumulator is pinned at full scale.
      acc_add = ovf_add ? '1 : sum[ACC_W-1:0];
`else
      acc_add = sum[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else if (last) begin
         out_data_q <= acc_add;
         out_ovf_q  <= ovf_add;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else if (accept) begin
         acc_q <= acc_add;
         ovf_q <= ovf_add;
      end else if (clear && !out_valid) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end
   end

   assign out_data = out_data_q;
   assign out_ovf  = out_ovf_q;

endmodule
